// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between two valid/ready requesters.
// Optional saturating grant counters are built when LOGIC_ARB_GRANT_CNT_EN is defined.
module logic_op_arbiter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [1:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [1:0]       req1_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_id,
   output logic             busy,
   output logic [7:0]       grant_cnt0,
   output logic [7:0]       grant_cnt1
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [1:0]       op_q, op_d;
   logic             id_q, id_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_id_q, rsp_id_d;

   logic             gnt0, gnt1, hs;
   logic [WIDTH-1:0] result;

   // Tie goes to the requester that was not granted last.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (req0_valid && req1_valid) begin
         gnt1 = ~last_grant_q;
         gnt0 = last_grant_q;
      end else begin
         gnt0 = req0_valid;
         gnt1 = req1_valid;
      end
   end

   assign hs = (state_q == StIdle) && (gnt0 || gnt1);

   always_comb begin
      unique case (op_q)
         2'b00:   result = a_q & b_q;
         2'b01:   result = a_q | b_q;
         2'b10:   result = a_q ^ b_q;
         default: result = ~(a_q & b_q);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (hs) state_d = StExec;
         StExec:  state_d = StResp;
         StResp:  if (rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      req0_ready = (state_q == StIdle) && gnt0;
      req1_ready = (state_q == StIdle) && gnt1;
      busy       = (state_q != StIdle);
   end

   always_comb begin
      last_grant_d = last_grant_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      id_d         = id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      rsp_id_d     = rsp_id_q;
      if (hs) begin
         a_d          = gnt1 ? req1_a : req0_a;
         b_d          = gnt1 ? req1_b : req0_b;
         op_d         = gnt1 ? req1_op : req0_op;
         id_d         = gnt1;
         last_grant_d = gnt1;
      end
      if (state_q == StExec) begin
         rsp_data_d  = result;
         rsp_id_d    = id_q;
         rsp_valid_d = 1'b1;
      end
      if (state_q == StResp && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         id_q         <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_id_q     <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         id_q         <= id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_id_q     <= rsp_id_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;

`ifdef LOGIC_ARB_GRANT_CNT_EN
   logic [7:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (hs && gnt0 && cnt0_q != 8'hFF) cnt0_d = cnt0_q + 8'd1;
      if (hs && gnt1 && cnt1_q != 8'hFF) cnt1_d = cnt1_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= 8'h00;
         cnt1_q <= 8'h00;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;
`else
   assign grant_cnt0 = 8'h00;
   assign grant_cnt1 = 8'h00;
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed self-checking bench for logic_op_arbiter: reset, opcodes, fairness, backpressure
// and the grant counters.
module tb_logic_op_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [7:0] req0_a, req0_b, req1_a, req1_b;
   logic [1:0] req0_op, req1_op;
   logic       rsp_valid, rsp_ready, rsp_id, busy;
   logic [7:0] rsp_data, grant_cnt0, grant_cnt1;

   int n_cmp  = 0;
   int n_fail = 0;

`ifdef LOGIC_ARB_GRANT_CNT_EN
   localparam logic [7:0] ExpCnt0 = 8'hFF;
`else
   localparam logic [7:0] ExpCnt0 = 8'h00;
`endif

   logic_op_arbiter #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_id     (rsp_id),
      .busy       (busy),
      .grant_cnt0 (grant_cnt0),
      .grant_cnt1 (grant_cnt1)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req0_valid = 0; req1_valid = 0; rsp_ready = 0;
      req0_a = 0; req0_b = 0; req0_op = 0;
      req1_a = 0; req1_b = 0; req1_op = 0;
      step(); step();
      rst_n = 1'b1;
      step();
      n_cmp++;
      if ({rsp_valid, busy, rsp_data, rsp_id, req0_ready, req1_ready} !== 13'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b busy=%b d=%h id=%b r0=%b r1=%b want all 0",
                  rsp_valid, busy, rsp_data, rsp_id, req0_ready, req1_ready);
      end
      n_cmp++;
      if ({grant_cnt0, grant_cnt1} !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_counts: got %h/%h want 00/00", grant_cnt0, grant_cnt1);
      end
      // Take requester 0 into RESP, then reset while the response is pending.
      req0_valid = 1; req0_a = 8'hFF; req0_b = 8'hFF; req0_op = 2'b00;
      step();
      req0_valid = 0;
      step();
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'hFF) begin
         n_fail++;
         $display("FAIL pre_reset_resp: got v=%b d=%h want 1/ff", rsp_valid, rsp_data);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 8'h00) begin
         n_fail++;
         $display("FAIL mid_resp_reset: got v=%b busy=%b d=%h want 0/0/00",
                  rsp_valid, busy, rsp_data);
      end
      step();
      rst_n = 1'b1;
      step();
      req0_valid = 1; req1_valid = 1;
      #1;
      n_cmp++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL first_tie_after_reset: got r0=%b r1=%b want 1/0", req0_ready, req1_ready);
      end
      req0_valid = 0; req1_valid = 0;
      step();
   endtask

   task automatic test_single_op();
      rsp_ready = 1;
      req0_valid = 1; req0_a = 8'hF0; req0_b = 8'h3C; req0_op = 2'b00;
      #1;
      n_cmp++;
      if (req0_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL single_ready: got %b want 1", req0_ready);
      end
      step();
      req0_valid = 0;
      n_cmp++;
      if (req0_ready !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_exec: got r0=%b busy=%b v=%b want 0/1/0",
                  req0_ready, busy, rsp_valid);
      end
      step();
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h30 || rsp_id !== 1'b0) begin
         n_fail++;
         $display("FAIL single_resp: got v=%b d=%h id=%b want 1/30/0", rsp_valid, rsp_data, rsp_id);
      end
      step();
      n_cmp++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 8'h30) begin
         n_fail++;
         $display("FAIL single_done: got v=%b busy=%b d=%h want 0/0/30", rsp_valid, busy, rsp_data);
      end
   endtask

   task automatic test_opcodes();
      logic [1:0] ops [3];
      logic [7:0] exp [3];
      ops[0] = 2'b01; exp[0] = 8'hAF;
      ops[1] = 2'b10; exp[1] = 8'hA5;
      ops[2] = 2'b11; exp[2] = 8'hF5;
      rsp_ready = 1;
      for (int i = 0; i < 3; i++) begin
         req1_valid = 1; req1_a = 8'hAA; req1_b = 8'h0F; req1_op = ops[i];
         #1;
         n_cmp++;
         if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL op%0d_ready: got r1=%b r0=%b want 1/0", i, req1_ready, req0_ready);
         end
         step();
         req1_valid = 0;
         step();
         n_cmp++;
         if (rsp_valid !== 1'b1 || rsp_data !== exp[i] || rsp_id !== 1'b1) begin
            n_fail++;
            $display("FAIL op%0d_resp: got v=%b d=%h id=%b want 1/%h/1",
                     i, rsp_valid, rsp_data, rsp_id, exp[i]);
         end
         step();
      end
   endtask

   task automatic test_contention();
      int grants = 0;
      int cyc = 0;
      rsp_ready = 1;
      req0_valid = 1; req0_a = 8'h0F; req0_b = 8'hFF; req0_op = 2'b00;
      req1_valid = 1; req1_a = 8'hF0; req1_b = 8'hFF; req1_op = 2'b00;
      #1;
      while (grants < 6 && cyc < 40) begin
         n_cmp++;
         if (req0_ready && req1_ready) begin
            n_fail++;
            $display("FAIL both_ready: got 1/1 in cycle %0d want at most one", cyc);
         end
         if (req0_ready || req1_ready) begin
            n_cmp++;
            if (req1_ready !== grants[0]) begin
               n_fail++;
               $display("FAIL grant_order%0d: got id %0d want %0d", grants, req1_ready, grants[0]);
            end
            grants++;
         end
         step();
         cyc++;
      end
      req0_valid = 0; req1_valid = 0;
      n_cmp++;
      if (grants != 6) begin
         n_fail++;
         $display("FAIL contention_timeout: got %0d grants want 6", grants);
      end
      step(); step();
   endtask

   task automatic test_backpressure();
      rsp_ready = 0;
      req0_valid = 1; req0_a = 8'h12; req0_b = 8'h34; req0_op = 2'b01;
      step();
      req0_valid = 0;
      req1_valid = 1; req1_a = 8'h55; req1_b = 8'h55; req1_op = 2'b00;
      step();
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (rsp_valid !== 1'b1 || rsp_data !== 8'h36 || rsp_id !== 1'b0 ||
             req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall%0d: got v=%b d=%h id=%b r0=%b r1=%b want 1/36/0/0/0",
                     i, rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready);
         end
         step();
      end
      req1_valid = 0;
      rsp_ready = 1;
      step();
      n_cmp++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 8'h36) begin
         n_fail++;
         $display("FAIL stall_release: got v=%b busy=%b d=%h want 0/0/36", rsp_valid, busy, rsp_data);
      end
   endtask

   task automatic test_grant_cnt();
      int accepted = 0;
      int cyc = 0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      rsp_ready = 1;
      req0_valid = 1; req0_a = 8'h01; req0_b = 8'h01; req0_op = 2'b00;
      #1;
      while (accepted < 300 && cyc < 2000) begin
         if (req0_ready) accepted++;
         step();
         cyc++;
      end
      req0_valid = 0;
      step(); step(); step();
      n_cmp++;
      if (accepted != 300) begin
         n_fail++;
         $display("FAIL cnt_timeout: got %0d accepts want 300", accepted);
      end
      n_cmp++;
      if (grant_cnt0 !== ExpCnt0 || grant_cnt1 !== 8'h00) begin
         n_fail++;
         $display("FAIL grant_counts: got %h/%h want %h/00", grant_cnt0, grant_cnt1, ExpCnt0);
      end
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_opcodes();
      test_contention();
      test_backpressure();
      test_grant_cnt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
